// File: rtl/memory_responder.sv
// Single-port request/ready memory responder with fixed wait states.
// Optional build macro MEMORY_RESPONDER_STATS_EN adds completed read/write counters.
module memory_responder #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ren,
   input  logic              wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              busy
`ifdef MEMORY_RESPONDER_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   logic [DATA_W-1:0] mem [DEPTH];
   state_t            state;
   req_t              req;
   logic [3:0]        cnt;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < (ADDR_W+1)'(DEPTH);
   endfunction

   // Out-of-range reads return zero rather than aliasing into the array.
   function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
      return in_range(a) ? mem[a[IW-1:0]] : '0;
   endfunction

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= IDLE;
         ready <= 1'b0;
         busy  <= 1'b0;
         rdata <= '0;
         cnt   <= '0;
         req   <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef MEMORY_RESPONDER_STATS_EN
         rd_count <= '0;
         wr_count <= '0;
`endif
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (ren | wen) begin
                  req  <= '{wr: wen, addr: addr, wdata: wdata};
                  cnt  <= 4'(LATENCY);
                  busy <= 1'b1;
                  if (LATENCY == 0) begin
                     state <= RESP;
                     ready <= 1'b1;
                     if (!wen) rdata <= rd_word(addr);
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= RESP;
                  ready <= 1'b1;
                  if (!req.wr) rdata <= rd_word(req.addr);
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (req.wr && in_range(req.addr)) mem[req.addr[IW-1:0]] <= req.wdata;
`ifdef MEMORY_RESPONDER_STATS_EN
               if (req.wr) begin
                  if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
               end else begin
                  if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
               end
`endif
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder (DEPTH=128, LATENCY=2).
module tb_memory_responder;

   logic       CLK = 1'b0, nRST = 1'b0, ren = 1'b0, wen = 1'b0;
   logic [7:0] addr = 8'h00, wdata = 8'h00;
   logic [7:0] rdata;
   logic       ready, busy;
`ifdef MEMORY_RESPONDER_STATS_EN
   logic [15:0] rd_count, wr_count;
`endif

   int         npass = 0, ntotal = 0;
   logic [7:0] mdl [128];
   logic [7:0] last_rd;
   logic [7:0] exp_q [$];

   memory_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .LATENCY(2)) dut (
      .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .busy(busy)
`ifdef MEMORY_RESPONDER_STATS_EN
      , .rd_count(rd_count), .wr_count(wr_count)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic model_reset();
      for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
      last_rd = 8'h00;
      exp_q.delete();
   endtask

   // Expected rdata at ready: the read word, or the held value for a write.
   task automatic expect_push(input logic w, input logic [7:0] a, input logic [7:0] d);
      if (w) begin
         if (a < 8'd128) mdl[a[6:0]] = d;
      end else begin
         last_rd = (a < 8'd128) ? mdl[a[6:0]] : 8'h00;
      end
      exp_q.push_back(last_rd);
   endtask

   task automatic access(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d,
                         output int lat, output int bcnt, output logic [7:0] rd);
      expect_push(w, a, d);
      @(negedge CLK);
      ren = r; wen = w; addr = a; wdata = d;
      lat = 0; bcnt = 0;
      do begin
         @(negedge CLK);
         lat++;
         if (busy) bcnt++;
      end while (!ready && lat < 20);
      rd  = rdata;
      ren = 1'b0; wen = 1'b0;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      model_reset();
      repeat (3) @(negedge CLK);
      ntotal++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else npass++;
      ntotal++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else npass++;
      ntotal++; if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h expected 00", rdata); else npass++;
`ifdef MEMORY_RESPONDER_STATS_EN
      ntotal++; if (rd_count !== 16'd0 || wr_count !== 16'd0)
         $display("FAIL reset_counts: got %0d/%0d expected 0/0", rd_count, wr_count); else npass++;
`endif
      nRST = 1'b1;
   endtask

   task automatic test_read();
      int lat, bcnt; logic [7:0] rd, exp;
      access(1'b0, 1'b1, 8'h10, 8'h00, lat, bcnt, rd);
      exp = exp_q.pop_front();
      ntotal++; if (lat !== 3) $display("FAIL read_latency: got %0d expected 3", lat); else npass++;
      ntotal++; if (bcnt !== 3) $display("FAIL read_busy_cycles: got %0d expected 3", bcnt); else npass++;
      ntotal++; if (rd !== exp) $display("FAIL read_rdata: got %h expected %h", rd, exp); else npass++;
      @(negedge CLK);
      ntotal++; if (ready !== 1'b0 || busy !== 1'b0)
         $display("FAIL read_pulse_end: got ready=%b busy=%b expected 0/0", ready, busy); else npass++;
   endtask

   task automatic test_write_read();
      int lat, bcnt; logic [7:0] rd, exp;
      access(1'b1, 1'b0, 8'h20, 8'hA5, lat, bcnt, rd);
      exp = exp_q.pop_front();
      ntotal++; if (lat !== 3) $display("FAIL write_latency: got %0d expected 3", lat); else npass++;
      ntotal++; if (rd !== exp) $display("FAIL write_rdata_held: got %h expected %h", rd, exp); else npass++;
      access(1'b0, 1'b1, 8'h20, 8'h00, lat, bcnt, rd);
      exp = exp_q.pop_front();
      ntotal++; if (rd !== exp) $display("FAIL raw_rdata: got %h expected %h", rd, exp); else npass++;
      ntotal++; if (lat !== 3) $display("FAIL raw_latency: got %0d expected 3", lat); else npass++;
      access(1'b1, 1'b0, 8'h21, 8'h11, lat, bcnt, rd);
      exp = exp_q.pop_front();
      ntotal++; if (rd !== exp) $display("FAIL write2_rdata_held: got %h expected %h", rd, exp); else npass++;
   endtask

   task automatic test_priority();
      int lat, bcnt; logic [7:0] rd, exp;
      access(1'b1, 1'b1, 8'h05, 8'h3C, lat, bcnt, rd);
      exp = exp_q.pop_front();
      ntotal++; if (lat !== 3) $display("FAIL prio_latency: got %0d expected 3", lat); else npass++;
      ntotal++; if (rd !== exp) $display("FAIL prio_rdata_held: got %h expected %h", rd, exp); else npass++;
      access(1'b0, 1'b1, 8'h05, 8'h00, lat, bcnt, rd);
      exp = exp_q.pop_front();
      ntotal++; if (rd !== exp) $display("FAIL prio_readback: got %h expected %h", rd, exp); else npass++;
      ntotal++; if (lat !== 3) $display("FAIL prio_read_latency: got %0d expected 3", lat); else npass++;
   endtask

   task automatic test_back_to_back();
      int lat; logic [7:0] exp;
      expect_push(1'b0, 8'h20, 8'h00);
      expect_push(1'b0, 8'h05, 8'h00);
      @(negedge CLK);
      ren = 1'b1; addr = 8'h20; lat = 0;
      do begin @(negedge CLK); lat++; end while (!ready && lat < 20);
      exp = exp_q.pop_front();
      ntotal++; if (lat !== 3) $display("FAIL b2b_first_latency: got %0d expected 3", lat); else npass++;
      ntotal++; if (rdata !== exp) $display("FAIL b2b_first_rdata: got %h expected %h", rdata, exp); else npass++;
      addr = 8'h05;
      @(negedge CLK);
      ntotal++; if (ready !== 1'b0 || busy !== 1'b0)
         $display("FAIL b2b_idle_gap: got ready=%b busy=%b expected 0/0", ready, busy); else npass++;
      lat = 1;
      do begin
         @(negedge CLK);
         lat++;
         if (lat == 2) addr = 8'h21;
      end while (!ready && lat < 20);
      exp = exp_q.pop_front();
      ntotal++; if (lat !== 4) $display("FAIL b2b_second_latency: got %0d expected 4", lat); else npass++;
      ntotal++; if (rdata !== exp) $display("FAIL b2b_second_rdata: got %h expected %h", rdata, exp); else npass++;
      ren = 1'b0;
   endtask

   task automatic test_out_of_range();
      int lat, bcnt; logic [7:0] rd, exp;
      access(1'b1, 1'b0, 8'h90, 8'hFF, lat, bcnt, rd);
      exp = exp_q.pop_front();
      ntotal++; if (lat !== 3) $display("FAIL oor_write_latency: got %0d expected 3", lat); else npass++;
      access(1'b0, 1'b1, 8'h90, 8'h00, lat, bcnt, rd);
      exp = exp_q.pop_front();
      ntotal++; if (lat !== 3) $display("FAIL oor_read_latency: got %0d expected 3", lat); else npass++;
      ntotal++; if (rd !== exp) $display("FAIL oor_read_rdata: got %h expected %h", rd, exp); else npass++;
      access(1'b0, 1'b1, 8'h10, 8'h00, lat, bcnt, rd);
      exp = exp_q.pop_front();
      ntotal++; if (rd !== exp) $display("FAIL oor_alias_rdata: got %h expected %h", rd, exp); else npass++;
   endtask

   task automatic test_reset_mid();
      int lat, bcnt; logic [7:0] rd, exp;
      @(negedge CLK);
      wen = 1'b1; addr = 8'h01; wdata = 8'h77;
      @(negedge CLK);
      nRST = 1'b0; wen = 1'b0;
      model_reset();
      @(negedge CLK);
      ntotal++; if (ready !== 1'b0 || busy !== 1'b0)
         $display("FAIL abort_state: got ready=%b busy=%b expected 0/0", ready, busy); else npass++;
      nRST = 1'b1;
      access(1'b0, 1'b1, 8'h01, 8'h00, lat, bcnt, rd);
      exp = exp_q.pop_front();
      ntotal++; if (rd !== exp) $display("FAIL abort_readback: got %h expected %h", rd, exp); else npass++;
      ntotal++; if (lat !== 3) $display("FAIL abort_read_latency: got %0d expected 3", lat); else npass++;
`ifdef MEMORY_RESPONDER_STATS_EN
      @(negedge CLK);
      ntotal++; if (rd_count !== 16'd1 || wr_count !== 16'd0)
         $display("FAIL abort_counts: got %0d/%0d expected 1/0", rd_count, wr_count); else npass++;
`endif
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_read();
      test_priority();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid();
      ntotal++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); else npass++;
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
